// File: rtl/pe_store_loader_if.sv
// Stream interface between the on-chip buffer and the PE column store loader.
//   inData  - stream word
//   inValid - stream word valid (buffer -> loader)
//   inReady - loader can accept a word this cycle (loader -> buffer)
// master: the buffer side (drives data/valid); slave: the loader side.
interface pe_store_loader_if #(
    parameter int unsigned W = 16
);
    logic [W-1:0] inData;
    logic         inValid;
    logic         inReady;

    modport master (output inData, output inValid, input inReady);
    modport slave  (input inData, input inValid, output inReady);
endinterface

// File: rtl/pe_store_loader.sv
// Writer side of one PE column's kernel/neuron local stores.
// Each job loads kernelCount kernel words, then neuronCount neuron words, from a valid/ready
// stream, and pulses done when the last write has been issued.
// Ports:
//   CLK, RSTn          - clock (rising edge), asynchronous active-low reset
//   start              - one-cycle job request, honoured only when idle and not busy
//   kernelCount        - kernel words for the job (0..2^A, larger values saturate)
//   neuronCount        - neuron words for the job (0..2^A, larger values saturate)
//   stream             - slave side of the word stream (inData/inValid/inReady)
//   kernelIn/neuronIn  - registered store write data, held between writes
//   columnControl      - {controlSignal[5:0], kernelWrite, neuronWrite}
//   busy, done         - job in progress, one-cycle completion pulse
//   checksum           - only with PE_STORE_LOADER_CHECKSUM_EN defined: modulo-2^W sum of all
//                        words accepted in the current job
module pe_store_loader #(
    parameter int unsigned W         = 16,
    parameter int unsigned A         = 7,
    parameter logic [5:0]  CTRL_HOLD = 6'h00,
    parameter logic [5:0]  CTRL_CLR  = 6'h01,
    parameter logic [5:0]  CTRL_INC  = 6'h02
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             start,
    input  logic [A:0]       kernelCount,
    input  logic [A:0]       neuronCount,
    pe_store_loader_if.slave stream,
    output logic [W-1:0]     kernelIn,
    output logic [W-1:0]     neuronIn,
    output logic [7:0]       columnControl,
    output logic             busy,
    output logic             done
`ifdef PE_STORE_LOADER_CHECKSUM_EN
    ,
    output logic [W-1:0]     checksum
`endif
);
    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StClrK  = 3'd1;
    localparam logic [2:0] StLoadK = 3'd2;
    localparam logic [2:0] StClrN  = 3'd3;
    localparam logic [2:0] StLoadN = 3'd4;
    localparam logic [2:0] StFin   = 3'd5;

    localparam logic [A:0] MaxCount = {1'b1, {A{1'b0}}};
    localparam logic [A:0] OneCount = {{A{1'b0}}, 1'b1};

    logic [2:0]   state_q, state_d;
    logic [A:0]   kcount_q, kcount_d;
    logic [A:0]   ncount_q, ncount_d;
    logic [A:0]   cnt_q, cnt_d;
    logic         in_ready_q, in_ready_d;
    logic [W-1:0] kernel_in_q, kernel_in_d;
    logic [W-1:0] neuron_in_q, neuron_in_d;
    logic [5:0]   ctrl_q, ctrl_d;
    logic         kwr_q, kwr_d;
    logic         nwr_q, nwr_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic         accept;
    logic         start_acc;
    logic [A:0]   k_sat, n_sat;
    logic [A:0]   cnt_inc;

    assign accept    = stream.inValid & in_ready_q;
    assign start_acc = (state_q == StIdle) && start && !busy_q;
    assign k_sat     = (kernelCount > MaxCount) ? MaxCount : kernelCount;
    assign n_sat     = (neuronCount > MaxCount) ? MaxCount : neuronCount;
    assign cnt_inc   = cnt_q + OneCount;

    always_comb begin
        state_d  = state_q;
        kcount_d = kcount_q;
        ncount_d = ncount_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        unique case (state_q)
            StIdle: begin
                if (start_acc) begin
                    kcount_d = k_sat;
                    ncount_d = n_sat;
                    busy_d   = 1'b1;
                    if (k_sat != '0)      state_d = StClrK;
                    else if (n_sat != '0) state_d = StClrN;
                    else                  state_d = StFin;
                end
            end
            StClrK: begin
                cnt_d   = '0;
                state_d = StLoadK;
            end
            StLoadK: begin
                if (accept) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == kcount_q) state_d = (ncount_q != '0) ? StClrN : StFin;
                end
            end
            StClrN: begin
                cnt_d   = '0;
                state_d = StLoadN;
            end
            StLoadN: begin
                if (accept) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == ncount_q) state_d = StFin;
                end
            end
            StFin: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // done is visible the cycle after FIN; busy drops one cycle after that.
        if (done_q) busy_d = 1'b0;
    end

    always_comb begin
        // Ready is a registered copy of "next state loads", so it falls right after the last accept.
        in_ready_d  = (state_d == StLoadK) || (state_d == StLoadN);
        kwr_d       = accept && (state_q == StLoadK);
        nwr_d       = accept && (state_q == StLoadN);
        kernel_in_d = kwr_d ? stream.inData : kernel_in_q;
        neuron_in_d = nwr_d ? stream.inData : neuron_in_q;
        done_d      = (state_q == StFin);
        if (accept) begin
            ctrl_d = CTRL_INC;
        end else if ((state_d == StClrK) || (state_d == StClrN)) begin
            // Entering a clear state straight from IDLE: issue CLR immediately.
            ctrl_d = CTRL_CLR;
        end else if (((state_q == StClrK) || (state_q == StClrN)) && (ctrl_q != CTRL_CLR)) begin
            // The clear-state cycle carried the previous phase's last INC; CLR follows it.
            ctrl_d = CTRL_CLR;
        end else begin
            ctrl_d = CTRL_HOLD;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= StIdle;
            kcount_q    <= '0;
            ncount_q    <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            kernel_in_q <= '0;
            neuron_in_q <= '0;
            ctrl_q      <= CTRL_HOLD;
            kwr_q       <= 1'b0;
            nwr_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            kcount_q    <= kcount_d;
            ncount_q    <= ncount_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            kernel_in_q <= kernel_in_d;
            neuron_in_q <= neuron_in_d;
            ctrl_q      <= ctrl_d;
            kwr_q       <= kwr_d;
            nwr_q       <= nwr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

`ifdef PE_STORE_LOADER_CHECKSUM_EN
    logic [W-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (start_acc)   sum_d = '0;
        else if (accept) sum_d = sum_q + stream.inData;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) sum_q <= '0;
        else       sum_q <= sum_d;
    end

    assign checksum = sum_q;
`endif

    assign stream.inReady = in_ready_q;
    assign kernelIn       = kernel_in_q;
    assign neuronIn       = neuron_in_q;
    assign columnControl  = {ctrl_q, kwr_q, nwr_q};
    assign busy           = busy_q;
    assign done           = done_q;
endmodule

// File: doc/pe_store_loader.md
Name: pe_store_loader

Overview:
- Writer side of a PE column's kernel/neuron local stores.
- Accepts a valid/ready word stream from the on-chip buffer and drives kernelIn, neuronIn, kernelWrite, neuronWrite and the 6-bit store-controller command for one PE column.
- Each job loads kernelCount kernel words, then neuronCount neuron words.
- Signals completion so the array sequencer can begin the MAC phase.

Parameters:
- W, 16, data word width.
- A, 7, local store address width; maximum words per store is 2^A.
- CTRL_HOLD, 6'h00, controlSignal code: hold store addresses.
- CTRL_CLR, 6'h01, controlSignal code: clear store address counters.
- CTRL_INC, 6'h02, controlSignal code: advance store address after write.

Ports:
- CLK  input  1  clock, rising edge.
- RSTn  input  1  asynchronous active-low reset.
- start  input  1  one-cycle job request; sampled only in IDLE.
- kernelCount  input  A+1  kernel words to load, 0..2^A; latched on accepted start.
- neuronCount  input  A+1  neuron words to load, 0..2^A; latched on accepted start.
- inData  input  W  stream word.
- inValid  input  1  stream word valid.
- inReady  output  1  loader can accept a word this cycle.
- kernelIn  output  W  data to the kernel store.
- neuronIn  output  W  data to the neuron store.
- columnControl  output  8  {controlSignal[5:0], kernelWrite, neuronWrite}.
- busy  output  1  job in progress.
- done  output  1  one-cycle pulse when the job finishes.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; controlSignal=CTRL_HOLD; internal counters 0.
- All outputs are registered. Data and write strobes appear 1 cycle after the accepting handshake.
- FSM states: IDLE, CLR_K, LOAD_K, CLR_N, LOAD_N, FIN.
- IDLE:
  - start=1 latches both counts and sets busy=1.
  - Next state is CLR_K if kernelCount!=0, else CLR_N if neuronCount!=0, else FIN.
  - start while busy is ignored.
- CLR_K / CLR_N: one cycle; controlSignal=CTRL_CLR; inReady=0. Then go to LOAD_K / LOAD_N.
- LOAD_K:
  - inReady=1 except on the cycle after the last word is accepted.
  - Each accepted word (inValid&&inReady): next cycle kernelIn=inData, kernelWrite=1, controlSignal=CTRL_INC; otherwise kernelWrite=0, controlSignal=CTRL_HOLD.
  - Counter increments per accept.
  - On accepting word number kernelCount, inReady drops the following cycle. Next state is CLR_N if neuronCount!=0, else FIN.
- LOAD_N: identical to LOAD_K but uses neuronIn/neuronWrite and neuronCount. Exits to FIN.
- Pipeline overlap: the final write strobe of a phase coincides with the first cycle of the next state (CLR_N or FIN). CLR is therefore issued at least 1 cycle after the last INC, and no command overlap occurs.
- kernelWrite and neuronWrite are never 1 in the same cycle.
- kernelIn/neuronIn hold their last value when not writing.
- FIN: done=1 for exactly one cycle; busy=0 from the next cycle; return to IDLE. start in the FIN cycle is ignored.
- Stalls: inValid=0 inserts bubbles with writes=0 and CTRL_HOLD. There is no timeout.
- Count of 2^A (A+1 bits, MSB set) is legal. Counts above 2^A are saturated to 2^A on latch.
- RSTn asserted mid-job: immediate abort to IDLE with reset output values. Partial store contents are undefined to the consumer.

Optional Feature:
- Macro: PE_STORE_LOADER_CHECKSUM_EN.
- Defined:
  - Extra output checksum [W-1:0]: modulo-2^W sum of all words accepted in the current job (kernel and neuron).
  - Cleared to 0 on accepted start and on reset.
  - Valid and stable from the done cycle until the next accepted start.
- Undefined: port and adder absent; all other behaviour identical.

Test Plan:
- kernelCount=3, neuronCount=2, inValid held 1, words 0x0011..0x0015 -> start+1: CTRL_CLR. Then kernelWrite on 3 consecutive cycles with kernelIn 0x0011,0x0012,0x0013 and CTRL_INC. Then CTRL_CLR, neuronWrite 0x0014,0x0015, done 1 cycle later; busy low after.
- Same job with inValid toggling 1,0,1,0 -> writes only on the cycles after accepts; CTRL_HOLD in gaps; total 3 kernel and 2 neuron writes.
- kernelCount=0, neuronCount=4 -> no CLR_K or kernelWrite; first command CTRL_CLR then 4 neuron writes.
- Both counts 0 -> done 2 cycles after start; no writes; inReady never 1.
- kernelCount=128 (A=7) -> exactly 128 kernel writes; inReady drops after the 128th accept. start pulsed mid-load is ignored.
- RSTn low after 2 kernel words -> all outputs 0 asynchronously; after release the next start runs a clean full job. With PE_STORE_LOADER_CHECKSUM_EN, words 0xFFFF,0x0002 -> checksum 0x0001.
